// File: rtl/csa_accumulator.sv
// rtl/csa_accumulator.sv - carry-save accumulator that compresses operand groups to a sum/carry pair
//
// Purpose:
//   Accepts a stream of BITS-wide operands and keeps a redundant sum/carry pair.
//   Each accepted operand costs one 3:2 compression, so there is no carry chain.
//   A group ends when an operand arrives with in_last, or when MAX_OPS operands
//   have been taken. The pair is then presented downstream for a carry-propagate
//   adder: (out_sum + out_carry) mod 2^BITS equals the group total.
//
// Ports:
//   clk        in   1        rising-edge clock
//   rst_n      in   1        asynchronous active-low reset
//   in_valid   in   1        operand valid
//   in_ready   out  1        operand accept (combinational from state and out_ready)
//   in_data    in   BITS     operand
//   in_last    in   1        final operand of a group
//   out_valid  out  1        group result valid
//   out_ready  in   1        downstream adder ready
//   out_sum    out  BITS     carry-save sum vector
//   out_carry  out  BITS     carry-save carry vector, already shifted left
//   out_count  out  CNT_W    operands in the group
//   out_trunc  out  1        group closed by MAX_OPS without in_last

module csa_accumulator #(
  parameter int BITS    = 8,
  parameter int MAX_OPS = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [BITS-1:0]                  in_data,
  input  logic                             in_last,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [BITS-1:0]                  out_sum,
  output logic [BITS-1:0]                  out_carry,
  output logic [$clog2(MAX_OPS+1)-1:0]     out_count,
  output logic                             out_trunc
);

  localparam int CNT_W = $clog2(MAX_OPS + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OPS);
  localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t            r_state;
  logic [BITS-1:0]   r_s;
  logic [BITS-1:0]   r_c;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_out_valid;
  logic              r_trunc;
  // Cleared by reset and set on the first clock edge afterwards, so in_ready
  // stays low until the block has actually been clocked out of reset.
  logic              r_live;

  logic              w_accept;
  logic              w_start;
  logic              w_start_close;
  logic              w_accum_close;
  logic [BITS-1:0]   w_maj;
  logic [BITS-1:0]   w_s_next;
  logic [BITS-1:0]   w_c_next;
  logic [CNT_W-1:0]  w_cnt_inc;

  always_comb begin
    in_ready = 1'b0;
    if (r_live) begin
      case (r_state)
        IDLE:    in_ready = 1'b1;
        ACCUM:   in_ready = 1'b1;
        HOLD:    in_ready = out_ready;
        default: in_ready = 1'b0;
      endcase
    end
  end

  assign w_accept = in_valid && in_ready;

  // In HOLD an accepted operand implies the result transfers on the same edge,
  // so it opens a new group exactly as it would from IDLE.
  assign w_start = w_accept && (r_state != ACCUM);

  // 3:2 compressor: per-bit full adder, majority shifted into the next column.
  // The shift drops the MSB carry-out and leaves bit 0 at zero; with BITS==1
  // the shifted vector is always zero.
  assign w_maj    = (r_s & r_c) | (r_s & in_data) | (r_c & in_data);
  assign w_s_next = r_s ^ r_c ^ in_data;
  assign w_c_next = w_maj << 1;

  assign w_cnt_inc     = r_cnt + ONE_CNT;
  assign w_start_close = in_last || (MAX_OPS == 1);
  assign w_accum_close = in_last || (w_cnt_inc == MAX_CNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_s         <= '0;
      r_c         <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_trunc     <= 1'b0;
      r_live      <= 1'b0;
    end else begin
      r_live <= 1'b1;
      if (w_start) begin
        r_s   <= in_data;
        r_c   <= '0;
        r_cnt <= ONE_CNT;
        if (w_start_close) begin
          r_state     <= HOLD;
          r_out_valid <= 1'b1;
          r_trunc     <= !in_last;
        end else begin
          r_state     <= ACCUM;
          r_out_valid <= 1'b0;
          r_trunc     <= 1'b0;
        end
      end else if (w_accept) begin
        // Only reachable in ACCUM.
        r_s   <= w_s_next;
        r_c   <= w_c_next;
        r_cnt <= w_cnt_inc;
        if (w_accum_close) begin
          r_state     <= HOLD;
          r_out_valid <= 1'b1;
          r_trunc     <= !in_last;
        end
      end else if ((r_state == HOLD) && out_ready) begin
        r_state     <= IDLE;
        r_out_valid <= 1'b0;
        r_trunc     <= 1'b0;
      end
    end
  end

  // The accumulator registers are not touched while a result is held, so they
  // double as the registered result outputs.
  assign out_valid = r_out_valid;
  assign out_sum   = r_s;
  assign out_carry = r_c;
  assign out_count = r_cnt;
  assign out_trunc = r_trunc;

endmodule

// File: tb/tb_csa_accumulator.sv
// tb/tb_csa_accumulator.sv - self-checking bench for csa_accumulator

module tb_csa_accumulator;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       in_valid = 1'b0;
  logic       in_last = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready;
  logic       out_valid;
  logic       out_trunc;
  logic [7:0] out_sum;
  logic [7:0] out_carry;
  logic [2:0] out_count;

  logic       b_in_valid = 1'b0;
  logic       b_in_last = 1'b0;
  logic       b_out_ready = 1'b0;
  logic [0:0] b_in_data = 1'b0;
  logic       b_in_ready;
  logic       b_out_valid;
  logic       b_out_trunc;
  logic [0:0] b_out_sum;
  logic [0:0] b_out_carry;
  logic [2:0] b_out_count;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  csa_accumulator #(.BITS(8), .MAX_OPS(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_carry (out_carry),
    .out_count (out_count),
    .out_trunc (out_trunc)
  );

  csa_accumulator #(.BITS(1), .MAX_OPS(4)) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .in_data   (b_in_data),
    .in_last   (b_in_last),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .out_sum   (b_out_sum),
    .out_carry (b_out_carry),
    .out_count (b_out_count),
    .out_trunc (b_out_trunc)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one operand until accepted; returns 1 time unit after the accepting edge.
  task automatic beat(input logic [7:0] d, input logic last);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!ok) check("beat_timeout", 32'd0, 32'd1);
  endtask

  typedef struct {
    int              n;
    logic [3:0][7:0] ops;
    logic            last;
    logic [7:0]      e_sum;
    logic [7:0]      e_carry;
    logic [7:0]      e_total;
    logic [2:0]      e_cnt;
    logic            e_trunc;
  } vec_t;

  vec_t vt [5];

  // Reference model state for the random phase: plain group arithmetic.
  int q_total [$];
  int q_cnt   [$];
  bit q_trunc [$];
  int g_sum;
  int g_n;

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{n:1, ops:{8'h00, 8'h00, 8'h00, 8'h5A}, last:1'b1,
              e_sum:8'h5A, e_carry:8'h00, e_total:8'h5A, e_cnt:3'd1, e_trunc:1'b0};
    vt[1] = '{n:3, ops:{8'h00, 8'h01, 8'h01, 8'hFF}, last:1'b1,
              e_sum:8'hFD, e_carry:8'h04, e_total:8'h01, e_cnt:3'd3, e_trunc:1'b0};
    vt[2] = '{n:4, ops:{8'h10, 8'h10, 8'h10, 8'h10}, last:1'b0,
              e_sum:8'h20, e_carry:8'h20, e_total:8'h40, e_cnt:3'd4, e_trunc:1'b1};
    vt[3] = '{n:4, ops:{8'h40, 8'h30, 8'h20, 8'h10}, last:1'b1,
              e_sum:8'h20, e_carry:8'h80, e_total:8'hA0, e_cnt:3'd4, e_trunc:1'b0};
    vt[4] = '{n:2, ops:{8'h00, 8'h00, 8'h80, 8'h80}, last:1'b1,
              e_sum:8'h00, e_carry:8'h00, e_total:8'h00, e_cnt:3'd2, e_trunc:1'b0};

    // Reset state
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_sum", out_sum, 0);
    check("rst_out_carry", out_carry, 0);
    check("rst_out_count", out_count, 0);
    check("rst_out_trunc", out_trunc, 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_release_in_ready_before_edge", in_ready, 0);
    step();
    check("rst_release_in_ready_after_edge", in_ready, 1);

    // Table-driven groups
    for (int i = 0; i < 5; i++) begin
      out_ready = 1'b0;
      for (int k = 0; k < vt[i].n; k++)
        beat(vt[i].ops[k], vt[i].last && (k == vt[i].n - 1));
      check($sformatf("t%0d_valid", i), out_valid, 1);
      check($sformatf("t%0d_sum", i), out_sum, vt[i].e_sum);
      check($sformatf("t%0d_carry", i), out_carry, vt[i].e_carry);
      check($sformatf("t%0d_total", i), 8'(out_sum + out_carry), vt[i].e_total);
      check($sformatf("t%0d_count", i), out_count, vt[i].e_cnt);
      check($sformatf("t%0d_trunc", i), out_trunc, vt[i].e_trunc);
      out_ready = 1'b1;
      step();
      check($sformatf("t%0d_drained", i), out_valid, 0);
    end

    // Closing by MAX_OPS, fifth beat opens the next group with no bubble
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) beat(8'h10, 1'b0);
    check("max_valid", out_valid, 1);
    check("max_total", 8'(out_sum + out_carry), 8'h40);
    check("max_count", out_count, 4);
    check("max_trunc", out_trunc, 1);
    beat(8'h10, 1'b0);
    check("max_next_valid", out_valid, 0);
    check("max_next_count", out_count, 1);
    check("max_next_trunc", out_trunc, 0);
    beat(8'h01, 1'b1);
    check("max_next_total", 8'(out_sum + out_carry), 8'h11);
    check("max_next_count2", out_count, 2);
    step();
    check("max_next_drained", out_valid, 0);

    // Backpressure in HOLD, then simultaneous result and operand transfer
    out_ready = 1'b0;
    beat(8'h22, 1'b1);
    in_valid = 1'b1;
    in_data  = 8'h33;
    in_last  = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_in_ready", in_ready, 0);
      step();
      check("bp_valid", out_valid, 1);
      check("bp_sum", out_sum, 8'h22);
      check("bp_carry", out_carry, 8'h00);
      check("bp_count", out_count, 1);
      check("bp_trunc", out_trunc, 0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    check("bp_new_valid", out_valid, 0);
    check("bp_new_sum", out_sum, 8'h33);
    check("bp_new_count", out_count, 1);
    beat(8'h01, 1'b1);
    check("bp_new_total", 8'(out_sum + out_carry), 8'h34);
    check("bp_new_count2", out_count, 2);
    step();

    // Mid-group reset discards the partial group
    beat(8'h03, 1'b0);
    beat(8'h04, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", in_ready, 0);
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_count", out_count, 0);
    check("mid_rst_sum", out_sum, 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("mid_rst_in_ready_before_edge", in_ready, 0);
    step();
    check("mid_rst_in_ready_after_edge", in_ready, 1);
    beat(8'h07, 1'b1);
    check("mid_rst_valid_after", out_valid, 1);
    check("mid_rst_total", 8'(out_sum + out_carry), 8'h07);
    check("mid_rst_count_after", out_count, 1);
    step();

    // BITS=1 instance: 1 + 1 + 1
    b_out_ready = 1'b0;
    b_in_valid  = 1'b1;
    b_in_data   = 1'b1;
    for (int k = 0; k < 3; k++) begin
      b_in_last = (k == 2);
      @(negedge clk);
      check("w1_in_ready", b_in_ready, 1);
      check("w1_carry_zero", b_out_carry, 0);
      step();
    end
    b_in_valid = 1'b0;
    b_in_last  = 1'b0;
    check("w1_valid", b_out_valid, 1);
    check("w1_sum", b_out_sum, 1);
    check("w1_carry", b_out_carry, 0);
    check("w1_count", b_out_count, 3);
    check("w1_trunc", b_out_trunc, 0);

    // Randomized traffic against the group-arithmetic model
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    g_sum = 0;
    g_n   = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      bit exp_ready;
      bit pending;
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 8'($urandom);
      in_last   = ($urandom_range(0, 3) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
      #1;
      pending   = (q_total.size() > 0);
      exp_ready = pending ? out_ready : 1'b1;
      check("rnd_valid", out_valid, pending);
      check("rnd_in_ready", in_ready, exp_ready);
      if (pending) begin
        check("rnd_total", 8'(out_sum + out_carry), q_total[0]);
        check("rnd_count", out_count, q_cnt[0]);
        check("rnd_trunc", out_trunc, q_trunc[0]);
        if (out_ready) begin
          void'(q_total.pop_front());
          void'(q_cnt.pop_front());
          void'(q_trunc.pop_front());
        end
      end
      if (in_valid && exp_ready) begin
        g_sum = (g_sum + int'(in_data)) % 256;
        g_n++;
        if (in_last || g_n == 4) begin
          q_total.push_back(g_sum);
          q_cnt.push_back(g_n);
          q_trunc.push_back(!in_last);
          g_sum = 0;
          g_n   = 0;
        end
      end
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    check("rnd_final_valid", out_valid, q_total.size() > 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
